// File: rtl/sweep_sequencer.sv
// sweep_sequencer
// Calibration sequencer for the light-tracking servo pair. Sweeps the
// horizontal axis, then the vertical axis, one servo step at a time, takes one
// light sample per position, and steps back to the brightest position before
// moving on. DONE pulses once both axes are parked at their maxima.
//
// Ports:
//   CLK, CNT_RST        clock (rising edge), asynchronous active-high reset
//   START               begin calibration (sampled in IDLE only)
//   ABORT               synchronous return to IDLE from any state
//   SAMPLE_VLD, SAMPLE  one-cycle light sample strobe and unsigned value
//   STEP_ACK            servo driver accepted the pending step
//   STEP_REQ, STEP_DIR  step request and direction (1 = forward, 0 = back)
//   AXIS                active axis (0 = horizontal, 1 = vertical)
//   BUSY, DONE, ERR     not idle / completion pulse / sticky ACK timeout
//   MAX_VAL             running maximum for the current axis
//
// Build option: define LAE_STEP_TIMEOUT_EN to add a STEP_ACK watchdog of
// TIMEOUT_CYC cycles. Without it ERR is held at 0.

module sweep_sequencer #(
   parameter int unsigned SAMPLE_W    = 12,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned SWEEP_STEPS = 180,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic                CLK,
   input  logic                CNT_RST,
   input  logic                START,
   input  logic                ABORT,
   input  logic                SAMPLE_VLD,
   input  logic [SAMPLE_W-1:0] SAMPLE,
   input  logic                STEP_ACK,
   output logic                STEP_REQ,
   output logic                STEP_DIR,
   output logic                AXIS,
   output logic                BUSY,
   output logic                DONE,
   output logic                ERR,
   output logic [SAMPLE_W-1:0] MAX_VAL
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] WAIT_S = 3'd1;
   localparam logic [2:0] STEP_F = 3'd2;
   localparam logic [2:0] RET    = 3'd3;
   localparam logic [2:0] FIN    = 3'd4;

   localparam int unsigned     STEPS_LIM = 32'd1 << CNT_W;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SWEEP_STEPS - 1);
   localparam logic [CNT_W-1:0] CNT_SAT   = '1;

   // Elaboration-time parameter sanity checks
   if (SWEEP_STEPS < 2 || SWEEP_STEPS > STEPS_LIM) begin : g_bad_steps
      $error("sweep_sequencer: SWEEP_STEPS must be in 2 .. 2**CNT_W");
   end
   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("sweep_sequencer: TIMEOUT_CYC must be at least 2");
   end

   logic [2:0]          state, state_nxt;
   logic                step_req_nxt;
   logic                step_dir_nxt;
   logic                axis_nxt;
   logic                busy_nxt;
   logic                done_nxt;
   logic                err_nxt;
   logic [SAMPLE_W-1:0] max_val_nxt;
   logic [CNT_W-1:0]    step_cnt, step_cnt_nxt;
   logic [CNT_W-1:0]    max_cnt, max_cnt_nxt;

`ifdef LAE_STEP_TIMEOUT_EN
   // Watchdog width follows TIMEOUT_CYC, not CNT_W
   localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   logic [TO_W-1:0] to_cnt, to_cnt_nxt;
`endif

   // State and output registers
   always_ff @(posedge CLK or posedge CNT_RST) begin
      if (CNT_RST) begin
         state    <= IDLE;
         STEP_REQ <= 1'b0;
         STEP_DIR <= 1'b0;
         AXIS     <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         ERR      <= 1'b0;
         MAX_VAL  <= '0;
         step_cnt <= '0;
         max_cnt  <= '0;
`ifdef LAE_STEP_TIMEOUT_EN
         to_cnt   <= '0;
`endif
      end else begin
         state    <= state_nxt;
         STEP_REQ <= step_req_nxt;
         STEP_DIR <= step_dir_nxt;
         AXIS     <= axis_nxt;
         BUSY     <= busy_nxt;
         DONE     <= done_nxt;
         ERR      <= err_nxt;
         MAX_VAL  <= max_val_nxt;
         step_cnt <= step_cnt_nxt;
         max_cnt  <= max_cnt_nxt;
`ifdef LAE_STEP_TIMEOUT_EN
         to_cnt   <= to_cnt_nxt;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt    = state;
      step_req_nxt = STEP_REQ;
      step_dir_nxt = STEP_DIR;
      axis_nxt     = AXIS;
      done_nxt     = 1'b0;
      err_nxt      = ERR;
      max_val_nxt  = MAX_VAL;
      step_cnt_nxt = step_cnt;
      max_cnt_nxt  = max_cnt;
      busy_nxt     = 1'b0;
`ifdef LAE_STEP_TIMEOUT_EN
      to_cnt_nxt   = '0;
`endif

      case (state)
         IDLE: begin
            if (START) begin
               axis_nxt     = 1'b0;
               max_val_nxt  = '0;
               step_cnt_nxt = '0;
               max_cnt_nxt  = '0;
               err_nxt      = 1'b0;
               state_nxt    = WAIT_S;
            end
         end

         WAIT_S: begin
            if (SAMPLE_VLD) begin
               // Ties keep the earlier maximum; max_cnt counts positions since it
               if (SAMPLE > MAX_VAL) begin
                  max_val_nxt = SAMPLE;
                  max_cnt_nxt = '0;
               end else if (max_cnt != CNT_SAT) begin
                  max_cnt_nxt = max_cnt + CNT_W'(1);
               end

               if (step_cnt == LAST_STEP) begin
                  // Raise the first return request on entry if one is needed
                  state_nxt    = RET;
                  step_dir_nxt = 1'b0;
                  step_req_nxt = (max_cnt_nxt != '0);
               end else begin
                  state_nxt    = STEP_F;
                  step_dir_nxt = 1'b1;
                  step_req_nxt = 1'b1;
               end
            end
         end

         STEP_F: begin
            if (STEP_REQ && STEP_ACK) begin
               step_cnt_nxt = step_cnt + CNT_W'(1);
               step_req_nxt = 1'b0;
               state_nxt    = WAIT_S;
            end
         end

         RET: begin
            // REQ low here is the check cycle between return steps
            if (STEP_REQ) begin
               if (STEP_ACK) begin
                  max_cnt_nxt  = max_cnt - CNT_W'(1);
                  step_req_nxt = 1'b0;
               end
            end else if (max_cnt == '0) begin
               if (!AXIS) begin
                  axis_nxt     = 1'b1;
                  max_val_nxt  = '0;
                  step_cnt_nxt = '0;
                  state_nxt    = WAIT_S;
               end else begin
                  done_nxt  = 1'b1;
                  state_nxt = FIN;
               end
            end else begin
               step_req_nxt = 1'b1;
            end
         end

         FIN: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt    = IDLE;
            step_req_nxt = 1'b0;
         end
      endcase

`ifdef LAE_STEP_TIMEOUT_EN
      // Watchdog: cycles spent with an unanswered step request
      if (STEP_REQ && !STEP_ACK) begin
         to_cnt_nxt = to_cnt + TO_W'(1);
         if (to_cnt == TO_LAST) begin
            state_nxt    = IDLE;
            step_req_nxt = 1'b0;
            err_nxt      = 1'b1;
            done_nxt     = 1'b0;
         end
      end
`endif

      // Abort wins over everything; a coincident ACK is not counted
      if (ABORT) begin
         state_nxt    = IDLE;
         step_req_nxt = 1'b0;
         done_nxt     = 1'b0;
         err_nxt      = ERR;
         axis_nxt     = AXIS;
         step_dir_nxt = STEP_DIR;
         max_val_nxt  = MAX_VAL;
         step_cnt_nxt = step_cnt;
         max_cnt_nxt  = max_cnt;
      end

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_sweep_sequencer.sv
// tb_sweep_sequencer
// Self-checking bench for sweep_sequencer. Drives directed and randomized
// calibrations and compares step counts, maxima, handshake timing and status
// against a sample-array reference model.

`timescale 1ns/1ps

module tb_sweep_sequencer;

   localparam int unsigned SAMPLE_W    = 12;
   localparam int unsigned CNT_W       = 8;
   localparam int unsigned N           = 8;
   localparam int unsigned TIMEOUT_CYC = 16;

   logic                CLK        = 1'b0;
   logic                CNT_RST    = 1'b1;
   logic                START      = 1'b0;
   logic                ABORT      = 1'b0;
   logic                SAMPLE_VLD = 1'b0;
   logic [SAMPLE_W-1:0] SAMPLE     = '0;
   logic                STEP_ACK   = 1'b0;
   logic                STEP_REQ;
   logic                STEP_DIR;
   logic                AXIS;
   logic                BUSY;
   logic                DONE;
   logic                ERR;
   logic [SAMPLE_W-1:0] MAX_VAL;

   int n_checks   = 0;
   int n_fail     = 0;
   int done_seen  = 0;

   logic [SAMPLE_W-1:0] smp [2][N];

   sweep_sequencer #(
      .SAMPLE_W    (SAMPLE_W),
      .CNT_W       (CNT_W),
      .SWEEP_STEPS (N),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .CLK        (CLK),
      .CNT_RST    (CNT_RST),
      .START      (START),
      .ABORT      (ABORT),
      .SAMPLE_VLD (SAMPLE_VLD),
      .SAMPLE     (SAMPLE),
      .STEP_ACK   (STEP_ACK),
      .STEP_REQ   (STEP_REQ),
      .STEP_DIR   (STEP_DIR),
      .AXIS       (AXIS),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .ERR        (ERR),
      .MAX_VAL    (MAX_VAL)
   );

   always #5 CLK = ~CLK;

   // DONE is stable across the rising edge, so this counts whole pulses
   always @(posedge CLK) if (DONE === 1'b1) done_seen++;

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected $finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_req"},  32'(STEP_REQ), 0);
      check_eq({tag, "_dir"},  32'(STEP_DIR), 0);
      check_eq({tag, "_axis"}, 32'(AXIS),     0);
      check_eq({tag, "_busy"}, 32'(BUSY),     0);
      check_eq({tag, "_done"}, 32'(DONE),     0);
      check_eq({tag, "_err"},  32'(ERR),      0);
      check_eq({tag, "_max"},  32'(MAX_VAL),  0);
   endtask

   task automatic drive_sample(input logic [SAMPLE_W-1:0] v);
      SAMPLE_VLD = 1'b1;
      SAMPLE     = v;
      @(negedge CLK);
      SAMPLE_VLD = 1'b0;
      SAMPLE     = SAMPLE_W'($urandom);
   endtask

   // Answers the pending request after dly cycles while injecting ignored noise
   task automatic do_ack(input int dly, input logic exp_dir, input logic exp_axis, input string tag);
      int hi;
      bit stable;
      hi     = 0;
      stable = 1'b1;
      check_eq({tag, "_dir"},  32'(STEP_DIR), 32'(exp_dir));
      check_eq({tag, "_axis"}, 32'(AXIS),     32'(exp_axis));
      for (int i = 0; i <= dly; i++) begin
         if (STEP_REQ === 1'b1) hi++;
         if (STEP_DIR !== exp_dir || AXIS !== exp_axis) stable = 1'b0;
         SAMPLE_VLD = 1'($urandom);
         SAMPLE     = '1;
         START      = 1'($urandom);
         STEP_ACK   = (i == dly);
         @(negedge CLK);
      end
      STEP_ACK   = 1'b0;
      SAMPLE_VLD = 1'b0;
      START      = 1'b0;
      check_eq({tag, "_req_hi"},  32'(hi), 32'(dly + 1));
      check_eq({tag, "_stable"},  32'(stable), 1);
      check_eq({tag, "_req_drop"}, 32'(STEP_REQ), 0);
   endtask

   task automatic wait_req(input string tag);
      for (int i = 0; i < 50 && STEP_REQ !== 1'b1; i++) @(negedge CLK);
      check_eq(tag, 32'(STEP_REQ), 1);
   endtask

   // Full calibration over smp[][]; expectations come from the sample arrays
   task automatic run_cal(input int dly_lo, input int dly_hi);
      int exp_max, last_new, exp_back, back, gap, done0;
      bit fin;
      done0 = done_seen;
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      check_eq("start_busy", 32'(BUSY),    1);
      check_eq("start_axis", 32'(AXIS),    0);
      check_eq("start_max",  32'(MAX_VAL), 0);
      check_eq("start_err",  32'(ERR),     0);
      for (int a = 0; a < 2; a++) begin
         // Reference: max starts at 0, only strictly larger samples move it
         exp_max  = 0;
         last_new = -1;
         for (int p = 0; p < int'(N); p++) begin
            if (32'(smp[a][p]) > exp_max) begin
               exp_max  = 32'(smp[a][p]);
               last_new = p;
            end
         end
         exp_back = int'(N) - 1 - last_new;

         for (int p = 0; p < int'(N); p++) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            drive_sample(smp[a][p]);
            if (p < int'(N) - 1) do_ack(int'($urandom_range(dly_hi, dly_lo)), 1'b1, 1'(a), "fwd");
         end
         check_eq("sweep_max", 32'(MAX_VAL), 32'(exp_max));

         back = 0;
         gap  = 1;
         fin  = 1'b0;
         for (int i = 0; i < 400 && !fin; i++) begin
            if (STEP_REQ === 1'b1) begin
               do_ack(int'($urandom_range(dly_hi, dly_lo)), 1'b0, 1'(a), "back");
               back++;
               gap = 1;
            end else if ((a == 0) ? (AXIS === 1'b1) : (DONE === 1'b1)) begin
               fin = 1'b1;
               check_eq("end_latency", 32'(gap), 2);
            end else begin
               @(negedge CLK);
               gap++;
            end
         end
         check_eq("end_reached", 32'(fin),  1);
         check_eq("back_steps",  32'(back), 32'(exp_back));
         if (a == 0) begin
            check_eq("switch_max", 32'(MAX_VAL), 0);
         end else begin
            check_eq("fin_busy", 32'(BUSY), 1);
            @(negedge CLK);
            check_eq("idle_done", 32'(DONE),    0);
            check_eq("idle_busy", 32'(BUSY),    0);
            check_eq("idle_axis", 32'(AXIS),    1);
            check_eq("idle_max",  32'(MAX_VAL), 32'(exp_max));
            check_eq("idle_err",  32'(ERR),     0);
            check_eq("done_once", 32'(done_seen - done0), 1);
         end
      end
   endtask

   task automatic fill_random(input bit narrow);
      for (int a = 0; a < 2; a++)
         for (int p = 0; p < int'(N); p++)
            smp[a][p] = narrow ? SAMPLE_W'($urandom_range(0, 3)) : SAMPLE_W'($urandom);
   endtask

   initial begin
      int d0;
      repeat (2) @(negedge CLK);
      check_reset_vals("reset");
      CNT_RST = 1'b0;
      @(negedge CLK);
      check_reset_vals("post_reset");

      // Single peak, ACK one cycle after each request
      smp[0] = '{12'd1, 12'd2, 12'd9, 12'd3, 12'd3, 12'd3, 12'd3, 12'd3};
      smp[1] = '{12'd5, 12'd4, 12'd4, 12'd4, 12'd4, 12'd4, 12'd4, 12'd4};
      run_cal(1, 1);

      // Tie: the first of equal maxima is kept
      fill_random(1'b0);
      smp[0] = '{12'd4, 12'd7, 12'd7, 12'd7, 12'd7, 12'd7, 12'd7, 12'd7};
      run_cal(0, 2);

      // Peak at the last horizontal position
      fill_random(1'b0);
      smp[0] = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd4095};
      run_cal(0, 2);

      // All-zero sweep never beats the initial maximum
      fill_random(1'b1);
      smp[1] = '{12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
      run_cal(0, 1);

      // Slow ACK: five cycles of delay on every step
      fill_random(1'b0);
      run_cal(5, 5);

      // CNT_RST mid-return
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      drive_sample(12'd9);
      do_ack(0, 1'b1, 1'b0, "rst_fwd");
      for (int p = 1; p < int'(N); p++) begin
         drive_sample(12'd1);
         if (p < int'(N) - 1) do_ack(0, 1'b1, 1'b0, "rst_fwd");
      end
      wait_req("rst_ret_req1");
      do_ack(0, 1'b0, 1'b0, "rst_back");
      wait_req("rst_ret_req2");
      CNT_RST = 1'b1;
      #1;
      check_reset_vals("mid_ret_reset");
      @(negedge CLK);
      CNT_RST = 1'b0;
      @(negedge CLK);
      check_eq("rst_release_busy", 32'(BUSY), 0);

      // ABORT coincident with STEP_ACK
      d0 = done_seen;
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      drive_sample(12'd9);
      wait_req("abort_req");
      ABORT    = 1'b1;
      STEP_ACK = 1'b1;
      @(negedge CLK);
      ABORT    = 1'b0;
      STEP_ACK = 1'b0;
      check_eq("abort_req_drop", 32'(STEP_REQ), 0);
      check_eq("abort_busy",     32'(BUSY),     0);
      check_eq("abort_max_held", 32'(MAX_VAL),  9);
      repeat (3) @(negedge CLK);
      check_eq("abort_no_done", 32'(done_seen - d0), 0);

`ifdef LAE_STEP_TIMEOUT_EN
      // Watchdog: request never acknowledged
      begin
         int hi;
         d0 = done_seen;
         START = 1'b1;
         @(negedge CLK);
         START = 1'b0;
         drive_sample(12'd5);
         hi = 0;
         for (int i = 0; i < 40 && STEP_REQ === 1'b1; i++) begin
            hi++;
            @(negedge CLK);
         end
         check_eq("to_req_cycles", 32'(hi),   TIMEOUT_CYC);
         check_eq("to_err",        32'(ERR),  1);
         check_eq("to_busy",       32'(BUSY), 0);
         check_eq("to_no_done",    32'(done_seen - d0), 0);
         START = 1'b1;
         @(negedge CLK);
         START = 1'b0;
         check_eq("to_err_clear", 32'(ERR),  0);
         check_eq("to_restart",   32'(BUSY), 1);
         ABORT = 1'b1;
         @(negedge CLK);
         ABORT = 1'b0;
         check_eq("to_abort_idle", 32'(BUSY), 0);
      end
`endif

      // Randomized calibrations
      for (int r = 0; r < 6; r++) begin
         fill_random(1'(r % 2));
         run_cal(0, 3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sweep_sequencer.md
# sweep_sequencer

- Calibration controller for the light-tracking servo pair.
- Sweeps the horizontal axis, then the vertical axis, one servo step at a time, taking one light sample per position.
- Tracks the brightest position during each sweep using an embedded max-distance counter, then steps the servo back to that position before moving to the next axis.
- Sits between the ADC sample path and the servo step driver; raises `DONE` when both axes are parked at their maxima.

## Interface
- `SAMPLE_W`, 12: width of light sample.
- `CNT_W`, 8: width of step and max-distance counters.
- `SWEEP_STEPS`, 180: positions per axis sweep. Legal range is 2 to 2^CNT_W.
- `TIMEOUT_CYC`, 1000000: ACK watchdog limit. Used only with the timeout macro.
- `CLK` input 1: clock. All logic is on the rising edge.
- `CNT_RST` input 1: reset, asynchronous, active-high.
- `START` input 1: begin calibration. Sampled only in IDLE.
- `ABORT` input 1: synchronous abort to IDLE from any state.
- `SAMPLE_VLD` input 1: one-cycle strobe qualifying `SAMPLE`.
- `SAMPLE` input SAMPLE_W: light level, unsigned.
- `STEP_ACK` input 1: servo driver accepted the step.
- `STEP_REQ` output 1: request one servo step.
- `STEP_DIR` output 1: step direction. 1 = forward (sweep), 0 = back (return).
- `AXIS` output 1: active axis. 0 = horizontal, 1 = vertical.
- `BUSY` output 1: high in every state except IDLE.
- `DONE` output 1: one-cycle pulse when calibration completes.
- `ERR` output 1: sticky timeout flag, cleared by the next accepted START.
- `MAX_VAL` output SAMPLE_W: running maximum for the current axis.

## Operation
- States: IDLE, WAIT_S, STEP_F, RET, FIN.
- **IDLE**
  - On `START`: AXIS←0, MAX_VAL←0, stepcnt←0, maxcnt←0, go to WAIT_S.
- **WAIT_S**
  - Waits for `SAMPLE_VLD`; on the strobe, compares `SAMPLE` with `MAX_VAL`.
  - If `SAMPLE` > `MAX_VAL` (strictly greater): MAX_VAL←SAMPLE, maxcnt←0. A tie keeps the earlier maximum and counts as "not greater".
  - Otherwise maxcnt←maxcnt+1, saturating at 2^CNT_W−1.
  - Then, if stepcnt == SWEEP_STEPS−1, go to RET; else go to STEP_F.
- **STEP_F**
  - STEP_REQ=1, STEP_DIR=1.
  - On `STEP_ACK`: stepcnt←stepcnt+1, go to WAIT_S.
- **RET**
  - If maxcnt == 0: the axis is complete.
    - With AXIS=0: AXIS←1, MAX_VAL←0, stepcnt←0, go to WAIT_S.
    - With AXIS=1: go to FIN.
  - Else: STEP_REQ=1, STEP_DIR=0. On `STEP_ACK`: maxcnt←maxcnt−1.
- **FIN**
  - DONE=1 for one cycle, then go to IDLE.
  - AXIS holds 1 until the next START.
- **Handshake**
  - STEP_REQ is registered and rises on entry to a step state.
  - STEP_REQ stays high until a cycle in which STEP_ACK=1; it is low in the following cycle.
  - STEP_DIR and AXIS are stable while STEP_REQ is high.
  - STEP_ACK is ignored while STEP_REQ=0.
  - In RET, after an ACK, REQ deasserts for one cycle before the next step request is raised.
- **Ignored inputs**
  - SAMPLE_VLD is ignored outside WAIT_S.
  - START is ignored outside IDLE.
- **ABORT**
  - Highest synchronous priority: next state is IDLE.
  - STEP_REQ is dropped even if STEP_ACK is high in the same cycle; that step is not counted.
  - MAX_VAL and ERR are held.

## Timing
- **Reset values:** STEP_REQ=0, STEP_DIR=0, AXIS=0, BUSY=0, DONE=0, ERR=0, MAX_VAL=0. Internal counters are 0 and the state is IDLE.
- **CNT_RST mid-operation:** returns to these values immediately; no step completes.
- **Latency:**
  - START to BUSY=1: 1 cycle.
  - SAMPLE_VLD to STEP_REQ=1: 1 cycle.
  - Last return ACK to DONE=1: 2 cycles (RET check, then FIN).
- **Outputs:** all outputs are registered; there are no combinational paths from input to output.

## Configuration
- Macro: `LAE_STEP_TIMEOUT_EN`.
- **Defined:**
  - A CNT_W-independent counter counts cycles while STEP_REQ=1 and clears on ACK.
  - On reaching TIMEOUT_CYC−1, the block sets ERR=1, drops STEP_REQ and goes to IDLE. DONE is not pulsed.
- **Undefined:** no watchdog; ERR is tied 0 and TIMEOUT_CYC is unused.

## Test plan
- **Single peak:** SWEEP_STEPS=8, ACK 1 cycle after each REQ. H samples 1,2,9,3,3,3,3,3; V samples 5,4,4,4,4,4,4,4. Require:
  - H phase: 7 forward steps, then 5 back steps; MAX_VAL=9.
  - V phase: 7 forward steps, then 7 back steps; MAX_VAL=5.
  - One DONE pulse.
- **Tie:** samples 4,7,7,7,… → the first 7 is kept; back-step count = SWEEP_STEPS−2.
- **Peak at last position:** H maximum on the final sample → zero back steps; AXIS→1 two cycles after the last sample.
- **Slow ACK:** STEP_ACK delayed 5 cycles → REQ held high for exactly 6 cycles, STEP_DIR stable throughout, exactly one step counted.
- **Reset and abort:** CNT_RST pulsed mid-RET → all outputs at reset values in the same cycle. ABORT coincident with ACK → IDLE, BUSY=0, no DONE.
- **Timeout (macro defined):** TIMEOUT_CYC=16, ACK never given → ERR=1 and STEP_REQ=0 after 16 REQ cycles. A subsequent START clears ERR.
